adc_sequencer: RTL and testbench
================================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 SHALL have parameter MADC, default 17, meaning comparison cycles per conversion (result bits).
REQ-002 SHALL have parameter NCH, default 4, meaning ADC channel count; CHW = max(1, clog2(NCH)).
REQ-003 SHALL have parameter SAMP_W, default 8, meaning sample-count width.
REQ-004 SHALL have ports, clock and reset first; the clock is single and reset is asynchronous, active-low:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-shot conversion request
- cont  in  1  continuous-conversion mode
- chan_mask  in  NCH  channels eligible for conversion
- samp_cycles  in  SAMP_W  sampling-phase length in clocks
- comp_out  in  NCH  per-channel comparator decision
- seq_init, seq_samp, seq_comp, seq_update  out  1 each  phase strobes
- chan_en  out  NCH  one-hot active channel
- busy  out  1  conversion in progress
- result_data  out  MADC  conversion result, MSB first decided
- result_chan  out  CHW  channel of result_data
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- overrun  out  1  one-cycle pulse when a result is dropped

Function
REQ-005 SHALL implement states IDLE, INIT, SAMP, COMP, UPDATE, DONE; exactly one seq_* strobe high in INIT/SAMP/COMP/UPDATE, none in IDLE/DONE.
REQ-006 IDLE -> INIT when (start or cont) and chan_mask != 0; otherwise remain IDLE; start with chan_mask == 0 ignored.
REQ-007 On entering INIT, channel SHALL be the next set bit of chan_mask after the previous channel, round-robin, wrapping NCH-1 -> 0; samp_cycles latched same cycle.
REQ-008 INIT lasts 1 cycle, then SAMP.
REQ-009 SAMP lasts max(latched samp_cycles, 1) cycles, then COMP with bit index = MADC-1.
REQ-010 COMP lasts 1 cycle, then UPDATE.
REQ-011 UPDATE lasts 1 cycle; comp_out[channel] captured into bit index; index 0 -> DONE, else index decrements and -> COMP.
REQ-012 Conversion length SHALL be 1 + S + 2*MADC cycles INIT through last UPDATE, plus 1 DONE cycle, S = max(samp_cycles,1).
REQ-013 chan_en SHALL be one-hot at channel from INIT through final UPDATE, zero otherwise; busy high in all states except IDLE.
REQ-014 In DONE: if result_valid is 0 or result_ready is 1, load result_data/result_chan and set result_valid next cycle; else keep old result and pulse overrun next cycle.
REQ-015 result_valid SHALL clear on result_valid and result_ready when no load coincides; simultaneous accept and load keeps result_valid 1 with new data.
REQ-016 DONE -> INIT (next channel) if cont is 1 and chan_mask != 0, else IDLE.
REQ-017 start while busy ignored; cont deasserted mid-conversion completes current conversion then IDLE; chan_mask changes affect only next INIT.
REQ-018 Result bits not yet decided SHALL read 0 in the internal shift register at INIT.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, all outputs 0, result register 0, previous-channel pointer NCH-1 (first conversion picks lowest set bit).
REQ-020 Reset mid-conversion SHALL abandon it without producing result_valid or overrun.

Structure
REQ-021 State enum and phase-strobe encoding SHALL reside in shared package adc_pkg.
REQ-022 Round-robin next-channel selection SHALL be sub-module adc_chansel (inputs mask, previous channel; outputs next channel, any).

Verification
REQ-023 MADC=17, samp_cycles=3, start pulse, chan_mask=0001, comp_out[0] pattern 1010... -> result_data=17'h15555, result_chan=0, result_valid 39 cycles after start seen in IDLE.
REQ-024 cont=1, chan_mask=1011, result_ready=1 -> result_chan sequence 0,1,3,0,1; chan_en one-hot matches each.
REQ-025 cont=1, result_ready=0 -> first result held, overrun pulses once per subsequent conversion, result_data unchanged.
REQ-026 samp_cycles=0 -> SAMP lasts 1 cycle; chan_mask=0 with start -> stays IDLE, busy 0.
REQ-027 rst_n low during COMP bit 8 -> all outputs 0 immediately; after release start on chan_mask=0100 -> result_chan=2.
REQ-028 result_ready high in same cycle as DONE load with result_valid=1 -> result_valid stays 1, new data presented, no overrun.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types for the ADC conversion sequencer: FSM states and the
// phase-strobe encoding that the sequencer drives out.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SAMP,
    ST_COMP,
    ST_UPDATE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic init;
    logic samp;
    logic comp;
    logic update;
  } strobe_t;

  // Phase strobes seen while sitting in state s; IDLE and DONE drive none.
  function automatic strobe_t strobe_of(input state_e s);
    strobe_t v;
    v = '0;
    case (s)
      ST_INIT:   v.init   = 1'b1;
      ST_SAMP:   v.samp   = 1'b1;
      ST_COMP:   v.comp   = 1'b1;
      ST_UPDATE: v.update = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adc_chansel.sv
// Round-robin channel picker: first set mask bit strictly after i_prev,
// wrapping NCH-1 -> 0 (i_prev itself is considered last).
module adc_chansel #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic [NCH-1:0] i_mask,
  input  logic [CHW-1:0] i_prev,
  output logic [CHW-1:0] o_next,
  output logic           o_any
);

  logic           w_found;
  logic [CHW-1:0] w_idx;

  always_comb begin
    o_next  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      w_idx = CHW'((32'(i_prev) + off) % NCH);
      if (!w_found && i_mask[w_idx]) begin
        o_next  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/adc_sequencer.sv
// Successive-approximation ADC sequencer: round-robin channel selection,
// sampling phase, MADC compare/update cycles and a one-deep result register.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned MADC   = 17,
  parameter int unsigned NCH    = 4,
  parameter int unsigned SAMP_W = 8,
  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [SAMP_W-1:0] samp_cycles,
  input  logic [NCH-1:0]    comp_out,
  output logic              seq_init,
  output logic              seq_samp,
  output logic              seq_comp,
  output logic              seq_update,
  output logic [NCH-1:0]    chan_en,
  output logic              busy,
  output logic [MADC-1:0]   result_data,
  output logic [CHW-1:0]    result_chan,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun
);

  localparam int unsigned BW = (MADC > 1) ? $clog2(MADC) : 1;

  state_e            r_state;
  strobe_t           r_strb;
  logic [CHW-1:0]    r_chan;
  logic [NCH-1:0]    r_chan_en;
  logic              r_busy;
  logic [SAMP_W-1:0] r_samp;
  logic [SAMP_W-1:0] r_cnt;
  logic [BW-1:0]     r_bit;
  logic [MADC-1:0]   r_shift;
  logic [MADC-1:0]   r_data;
  logic [CHW-1:0]    r_rchan;
  logic              r_valid;
  logic              r_overrun;

  logic [CHW-1:0]    w_next_chan;
  logic              w_any;
  logic              w_enter_init;

  adc_chansel #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_chansel (
    .i_mask (chan_mask),
    .i_prev (r_chan),
    .o_next (w_next_chan),
    .o_any  (w_any)
  );

  // r_chan doubles as the previous-channel pointer for the round-robin.
  assign w_enter_init = w_any &&
                        (((r_state == ST_IDLE) && (start || cont)) ||
                         ((r_state == ST_DONE) && cont));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_strb    <= '0;
      r_chan    <= CHW'(NCH - 1);
      r_chan_en <= '0;
      r_busy    <= 1'b0;
      r_samp    <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_rchan   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && result_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_strb <= '0;
        end
        ST_INIT: begin
          r_state <= ST_SAMP;
          r_strb  <= strobe_of(ST_SAMP);
          r_cnt   <= (r_samp == '0) ? SAMP_W'(1) : r_samp;
        end
        ST_SAMP: begin
          if (r_cnt <= SAMP_W'(1)) begin
            r_state <= ST_COMP;
            r_strb  <= strobe_of(ST_COMP);
            r_bit   <= BW'(MADC - 1);
          end else begin
            r_cnt <= r_cnt - SAMP_W'(1);
          end
        end
        ST_COMP: begin
          r_state <= ST_UPDATE;
          r_strb  <= strobe_of(ST_UPDATE);
        end
        ST_UPDATE: begin
          r_shift[r_bit] <= comp_out[r_chan];
          if (r_bit == '0) begin
            r_state   <= ST_DONE;
            r_strb    <= '0;
            r_chan_en <= '0;
          end else begin
            r_bit   <= r_bit - BW'(1);
            r_state <= ST_COMP;
            r_strb  <= strobe_of(ST_COMP);
          end
        end
        ST_DONE: begin
          // A pending unaccepted result wins; the new one is dropped.
          if (!r_valid || result_ready) begin
            r_data  <= r_shift;
            r_rchan <= r_chan;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
          r_state <= ST_IDLE;
          r_strb  <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_strb  <= '0;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_enter_init) begin
        r_state   <= ST_INIT;
        r_strb    <= strobe_of(ST_INIT);
        r_busy    <= 1'b1;
        r_chan    <= w_next_chan;
        r_chan_en <= NCH'(1) << w_next_chan;
        r_samp    <= samp_cycles;
        r_shift   <= '0;
      end
    end
  end

  assign seq_init     = r_strb.init;
  assign seq_samp     = r_strb.samp;
  assign seq_comp     = r_strb.comp;
  assign seq_update   = r_strb.update;
  assign chan_en      = r_chan_en;
  assign busy         = r_busy;
  assign result_data  = r_data;
  assign result_chan  = r_rchan;
  assign result_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_sequencer.sv
// Scoreboard bench for adc_sequencer: directed scenarios push expected
// results; a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_adc_sequencer;

  localparam int MADC   = 17;
  localparam int NCH    = 4;
  localparam int SAMP_W = 8;
  localparam int CHW    = 2;

  typedef struct packed {
    logic [MADC-1:0] data;
    logic [CHW-1:0]  chan;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic [NCH-1:0]    chan_mask = '0;
  logic [SAMP_W-1:0] samp_cycles = '0;
  logic [NCH-1:0]    comp_out;
  logic              seq_init, seq_samp, seq_comp, seq_update;
  logic [NCH-1:0]    chan_en;
  logic              busy;
  logic [MADC-1:0]   result_data;
  logic [CHW-1:0]    result_chan;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic              overrun;

  adc_sequencer #(.MADC(MADC), .NCH(NCH), .SAMP_W(SAMP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .chan_mask(chan_mask), .samp_cycles(samp_cycles), .comp_out(comp_out),
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp),
    .seq_update(seq_update), .chan_en(chan_en), .busy(busy),
    .result_data(result_data), .result_chan(result_chan),
    .result_valid(result_valid), .result_ready(result_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Comparator model: each channel replays its own MSB-first bit pattern.
  logic [MADC-1:0] pat [NCH];
  int upd_cnt = 0;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      comp_out[c] = (upd_cnt < MADC) ? pat[c][MADC-1-upd_cnt] : 1'b0;
    end
  end

  always @(posedge clk) begin
    if (seq_init)        upd_cnt <= 0;
    else if (seq_update) upd_cnt <= upd_cnt + 1;
  end

  exp_t           sb_q [$];
  logic [NCH-1:0] en_q [$];
  int             n_init = 0;
  int             n_ovr = 0;
  int             samp_run = 0;
  int             last_samp = 0;
  logic [NCH-1:0] cur_en = '0;
  logic [3:0]     strb;
  exp_t           e;

  // Monitor: invariants every cycle plus scoreboard pop on each accept.
  always @(negedge clk) begin
    if (rst_n) begin
      strb = {seq_init, seq_samp, seq_comp, seq_update};
      chk("strobe_onehot0", 64'($countones(strb) <= 1), 64'd1);
      if (seq_init) begin
        n_init++;
        cur_en = chan_en;
        if (en_q.size() > 0) chk("chan_en_at_init", 64'(chan_en), 64'(en_q.pop_front()));
      end
      if (strb != 4'd0) begin
        chk("busy_in_phase", 64'(busy), 64'd1);
        chk("chan_en_onehot", 64'($countones(chan_en)), 64'd1);
        if (!seq_init) chk("chan_en_hold", 64'(chan_en), 64'(cur_en));
      end else begin
        chk("chan_en_zero", 64'(chan_en), 64'd0);
      end
      if (seq_samp) samp_run++;
      else if (samp_run != 0) begin
        last_samp = samp_run;
        samp_run  = 0;
      end
      if (overrun) n_ovr++;
      if (result_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got data %0h chan %0d expected none", result_data, result_chan);
        end else begin
          e = sb_q.pop_front();
          chk("result_data", 64'(result_data), 64'(e.data));
          chk("result_chan", 64'(result_chan), 64'(e.chan));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_seq"}, 64'({seq_init, seq_samp, seq_comp, seq_update}), 64'd0);
    chk({tag, "_chan_en"}, 64'(chan_en), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rdata"}, 64'(result_data), 64'd0);
    chk({tag, "_rchan"}, 64'(result_chan), 64'd0);
    chk({tag, "_rvalid"}, 64'(result_valid), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    cont  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_inits(input int target);
    int n = 0;
    while (n_init < target && n < 2000) begin
      tick();
      n++;
    end
    chk("init_count_reached", 64'(n_init >= target), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base;
    int ovr0;
    pat[0] = 17'h15555;
    pat[1] = 17'h0ACE1;
    pat[2] = 17'h1F00F;
    pat[3] = 17'h12345;

    // Single shot on channel 0: latency, data, sampling length.
    do_reset();
    chan_mask = 4'b0001;
    samp_cycles = 8'd3;
    result_ready = 1'b0;
    en_q.push_back(4'b0001);
    pulse_start();
    cnt = 0;
    while (!result_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("latency", 64'(cnt), 64'd39);
    chk("single_data", 64'(result_data), 64'h15555);
    chk("single_chan", 64'(result_chan), 64'd0);
    chk("samp_len_3", 64'(last_samp), 64'd3);
    chk("single_busy_after", 64'(busy), 64'd0);
    sb_q.push_back('{data: 17'h15555, chan: 2'd0});
    result_ready = 1'b1;
    tick();
    tick();
    chk("single_valid_cleared", 64'(result_valid), 64'd0);

    // Continuous round robin over mask 1011.
    do_reset();
    chan_mask = 4'b1011;
    samp_cycles = 8'd2;
    result_ready = 1'b1;
    sb_q.push_back('{data: pat[0], chan: 2'd0});
    sb_q.push_back('{data: pat[1], chan: 2'd1});
    sb_q.push_back('{data: pat[3], chan: 2'd3});
    sb_q.push_back('{data: pat[0], chan: 2'd0});
    sb_q.push_back('{data: pat[1], chan: 2'd1});
    en_q.push_back(4'b0001);
    en_q.push_back(4'b0010);
    en_q.push_back(4'b1000);
    en_q.push_back(4'b0001);
    en_q.push_back(4'b0010);
    base = n_init;
    cont = 1'b1;
    wait_inits(base + 5);
    cont = 1'b0;
    wait_idle("rr");
    tick();
    tick();
    chk("rr_sb_drained", 64'(sb_q.size()), 64'd0);
    chk("rr_conversions", 64'(n_init - base), 64'd5);

    // Empty mask ignored, then samp_cycles = 0 behaves as 1.
    do_reset();
    chan_mask = 4'b0000;
    base = n_init;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("empty_mask_busy", 64'(busy), 64'd0);
      tick();
    end
    chk("empty_mask_no_init", 64'(n_init - base), 64'd0);
    chan_mask = 4'b0100;
    samp_cycles = 8'd0;
    result_ready = 1'b1;
    en_q.push_back(4'b0100);
    sb_q.push_back('{data: pat[2], chan: 2'd2});
    pulse_start();
    wait_idle("samp0");
    tick();
    chk("samp_len_1", 64'(last_samp), 64'd1);

    // Overrun: consumer stalled, first result must be held.
    do_reset();
    result_ready = 1'b0;
    chan_mask = 4'b0011;
    samp_cycles = 8'd1;
    en_q.push_back(4'b0001);
    en_q.push_back(4'b0010);
    en_q.push_back(4'b0001);
    en_q.push_back(4'b0010);
    base = n_init;
    ovr0 = n_ovr;
    cont = 1'b1;
    wait_inits(base + 4);
    cont = 1'b0;
    wait_idle("ovr");
    tick();
    chk("ovr_pulses", 64'(n_ovr - ovr0), 64'd3);
    chk("ovr_valid_held", 64'(result_valid), 64'd1);
    chk("ovr_data_held", 64'(result_data), 64'(pat[0]));
    chk("ovr_chan_held", 64'(result_chan), 64'd0);
    sb_q.push_back('{data: pat[0], chan: 2'd0});
    result_ready = 1'b1;
    tick();
    tick();
    chk("ovr_valid_cleared", 64'(result_valid), 64'd0);

    // Accept and load in the same DONE cycle.
    do_reset();
    result_ready = 1'b0;
    chan_mask = 4'b0001;
    samp_cycles = 8'd1;
    en_q.push_back(4'b0001);
    pulse_start();
    wait_idle("sim1");
    tick();
    chk("sim_first_valid", 64'(result_valid), 64'd1);
    sb_q.push_back('{data: pat[0], chan: 2'd0});
    chan_mask = 4'b0010;
    en_q.push_back(4'b0010);
    pulse_start();
    cnt = 0;
    while (!(busy && !seq_init && !seq_samp && !seq_comp && !seq_update) && cnt < 500) begin
      tick();
      cnt++;
    end
    chk("sim_reached_done", 64'(cnt < 500), 64'd1);
    ovr0 = n_ovr;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("sim_valid_kept", 64'(result_valid), 64'd1);
    chk("sim_new_data", 64'(result_data), 64'(pat[1]));
    chk("sim_new_chan", 64'(result_chan), 64'd1);
    tick();
    chk("sim_no_overrun", 64'(n_ovr - ovr0), 64'd0);
    sb_q.push_back('{data: pat[1], chan: 2'd1});
    result_ready = 1'b1;
    tick();
    tick();
    chk("sim_valid_cleared", 64'(result_valid), 64'd0);

    // Reset in the middle of a conversion (compare of bit 8).
    do_reset();
    chan_mask = 4'b0001;
    samp_cycles = 8'd2;
    result_ready = 1'b1;
    en_q.push_back(4'b0001);
    pulse_start();
    cnt = 0;
    while (!(seq_comp && upd_cnt == 8) && cnt < 500) begin
      tick();
      cnt++;
    end
    chk("abort_reached_bit8", 64'(cnt < 500), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    tick();
    rst_n = 1'b1;
    tick();
    check_zero("abort_after");
    chan_mask = 4'b0100;
    samp_cycles = 8'd1;
    en_q.push_back(4'b0100);
    sb_q.push_back('{data: pat[2], chan: 2'd2});
    pulse_start();
    wait_idle("abort_restart");
    tick();
    tick();

    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("final_en_q_empty", 64'(en_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
